// File: rtl/speed_sched.sv
// Speed-select scheduler: debounced up/down buttons or an automatic ping-pong sweep
// drive a 2-bit clock-mux select, with a guard window that holds gate low after each change.
module speed_sched #(
  parameter int DEB   = 50000,
  parameter int DWELL = 100000000,
  parameter int GUARD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  input  logic       auto_i,
  output logic [1:0] sel_o,
  output logic       gate_o,
  output logic       changed_o
);

  localparam int DBW = (DEB   > 1) ? $clog2(DEB)   : 1;
  localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW  = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [DBW-1:0] DEB_MAX   = DBW'(DEB - 1);
  localparam logic [DW-1:0]  DWELL_MAX = DW'(DWELL - 1);
  localparam logic [GW-1:0]  GUARD_MAX = GW'(GUARD - 1);

  typedef enum logic {RUN, HOLD} state_e;

  // Synchronizers: bit0 = up, bit1 = dn, bit2 = auto
  logic [2:0] sync0_q, sync1_q;
  logic [1:0] sync_vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q    <= '0;
      sync1_q    <= '0;
      sync_vld_q <= '0;
    end else begin
      sync0_q    <= {auto_i, btn_dn_i, btn_up_i};
      sync1_q    <= sync0_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  logic [1:0] btn_s;
  logic       auto_s;
  assign btn_s  = sync1_q[1:0];
  assign auto_s = sync1_q[2];

  // Debounce; a button is armed only once it has been seen released after reset,
  // so a button held through reset never yields a press.
  logic [DBW-1:0] deb_cnt_q [2];
  logic [DBW-1:0] deb_cnt_d [2];
  logic [1:0]     acc_q, acc_d, arm_q, arm_d, press;

  always_comb begin
    acc_d = acc_q;
    arm_d = arm_q;
    press = '0;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (btn_s[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          acc_d[i] = btn_s[i];
          press[i] = btn_s[i] & arm_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
      if (sync_vld_q[1] && !btn_s[i] && !acc_q[i]) arm_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      acc_q <= '0;
      arm_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      acc_q <= acc_d;
      arm_q <= arm_d;
    end
  end

  logic press_up, press_dn;
  assign press_up = press[0];
  assign press_dn = press[1];

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            gate_q, gate_d, changed_q, changed_d;
  logic            dir_q, dir_d, auto_prev_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            step_en, step_up, auto_rise;

  assign auto_rise = auto_s & ~auto_prev_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    dwell_d   = dwell_q;
    guard_d   = guard_q;
    changed_d = 1'b0;
    step_en   = 1'b0;
    step_up   = 1'b0;

    if (auto_rise) begin
      dwell_d = '0;
      dir_d   = (sel_q != 2'd3);
    end

    case (state_q)
      RUN: begin
        if (auto_s) begin
          if (!auto_rise) begin
            if (dwell_q == DWELL_MAX) begin
              dwell_d = '0;
              step_en = 1'b1;
              step_up = dir_q;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end else if (press_up && !press_dn && sel_q != 2'd3) begin
          step_en = 1'b1;
          step_up = 1'b1;
        end else if (press_dn && !press_up && sel_q != 2'd0) begin
          step_en = 1'b1;
          step_up = 1'b0;
        end
      end
      HOLD: begin
        if (guard_q == '0) state_d = RUN;
        else               guard_d = guard_q - 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Every select update opens a guard window; sweep direction turns at the ends.
    if (step_en) begin
      sel_d     = step_up ? sel_q + 2'd1 : sel_q - 2'd1;
      changed_d = 1'b1;
      state_d   = HOLD;
      guard_d   = GUARD_MAX;
      if (sel_d == 2'd3)      dir_d = 1'b0;
      else if (sel_d == 2'd0) dir_d = 1'b1;
    end

    gate_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      sel_q       <= 2'd0;
      gate_q      <= 1'b1;
      changed_q   <= 1'b0;
      dir_q       <= 1'b1;
      dwell_q     <= '0;
      guard_q     <= '0;
      auto_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gate_q      <= gate_d;
      changed_q   <= changed_d;
      dir_q       <= dir_d;
      dwell_q     <= dwell_d;
      guard_q     <= guard_d;
      auto_prev_q <= auto_s;
    end
  end

  assign sel_o     = sel_q;
  assign gate_o    = gate_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_speed_sched.sv
// Scoreboard bench for speed_sched: expected select values are queued as stimulus
// is applied and compared whenever the DUT pulses changed.
module tb_speed_sched;
  localparam int DEB   = 4;
  localparam int DWELL = 10;
  localparam int GUARD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       auto_m = 1'b0;
  logic [1:0] sel;
  logic       gate, changed;

  int n_tests = 0;
  int n_fail  = 0;
  int q_exp[$];
  int m_sel = 0;
  int n_chg = 0;
  int n_exp = 0;
  int cyc   = 0;
  bit gap_en = 1'b0;
  bit gap_armed = 1'b0;
  int last_chg = 0;
  int glow = 0;
  logic       prev_gate = 1'b1;
  logic [1:0] prev_sel = 2'd0;

  speed_sched #(.DEB(DEB), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .btn_up_i  (btn_up),
    .btn_dn_i  (btn_dn),
    .auto_i    (auto_m),
    .sel_o     (sel),
    .gate_o    (gate),
    .changed_o (changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input int dir);
    if (dir > 0 && m_sel < 3) begin
      m_sel++;
      q_exp.push_back(m_sel);
      n_exp++;
    end else if (dir < 0 && m_sel > 0) begin
      m_sel--;
      q_exp.push_back(m_sel);
      n_exp++;
    end
  endtask

  task automatic press_btn(input bit up, input bit dn, input int hold);
    btn_up = up;
    btn_dn = dn;
    tick(hold);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(hold);
  endtask

  task automatic wait_sb(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (q_exp.size() == 0) break;
      tick(1);
    end
    chk("sb_drain", q_exp.size(), 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    chk("rst_sel", int'(sel), 0);
    chk("rst_gate", int'(gate), 1);
    chk("rst_changed", int'(changed), 0);
    q_exp.delete();
    m_sel = 0;
    n_exp = n_chg;
    tick(3);
    rst_n = 1'b1;
    tick(5);
  endtask

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      glow      = 0;
      prev_gate = 1'b1;
      prev_sel  = sel;
    end else begin
      if (!gate) begin
        glow++;
      end else if (glow != 0) begin
        chk("gate_low_len", glow, GUARD);
        glow = 0;
      end
      if (!gate && prev_gate) chk("gate_fall_chg", int'(changed), 1);
      if (sel != prev_sel && !changed) chk("sel_silent", int'(sel), int'(prev_sel));
      if (changed) begin
        n_chg++;
        if (q_exp.size() > 0) chk("sel_step", int'(sel), q_exp.pop_front());
        if (gap_en && gap_armed) chk("dwell_gap", cyc - last_chg, DWELL + GUARD);
        gap_armed = gap_en;
        last_chg  = cyc;
      end
      prev_gate = gate;
      prev_sel  = sel;
    end
  end

  initial begin
    tick(1);
    reset_dut();

    // Clean single press
    expect_step(1);
    press_btn(1'b1, 1'b0, 10);
    wait_sb(20);
    tick(6);
    chk("clean_sel", int'(sel), m_sel);
    chk("clean_count", n_chg, n_exp);

    // Bouncing input never settles long enough
    for (int i = 0; i < 20; i++) begin
      btn_up = ~btn_up;
      tick(2);
    end
    btn_up = 1'b0;
    tick(10);
    chk("bounce_sel", int'(sel), m_sel);
    chk("bounce_count", n_chg, n_exp);

    // Up to the top, saturate, down to the bottom, saturate, simultaneous
    for (int i = 0; i < 3; i++) begin
      expect_step(1);
      press_btn(1'b1, 1'b0, 10);
      wait_sb(20);
      tick(6);
      chk("up_sel", int'(sel), m_sel);
    end
    for (int i = 0; i < 4; i++) begin
      expect_step(-1);
      press_btn(1'b0, 1'b1, 10);
      wait_sb(20);
      tick(6);
      chk("dn_sel", int'(sel), m_sel);
    end
    press_btn(1'b1, 1'b1, 10);
    tick(6);
    chk("both_sel", int'(sel), m_sel);
    chk("both_gate", int'(gate), 1);
    chk("sat_count", n_chg, n_exp);

    // Second press accepted one cycle later lands in HOLD and is dropped
    expect_step(1);
    btn_up = 1'b1;
    tick(1);
    btn_dn = 1'b1;
    tick(10);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(15);
    wait_sb(5);
    chk("hold_press_sel", int'(sel), m_sel);
    chk("hold_press_count", n_chg, n_exp);

    // Auto ping-pong sweep from 0
    reset_dut();
    for (int i = 0; i < 3; i++) expect_step(1);
    for (int i = 0; i < 3; i++) expect_step(-1);
    gap_en    = 1'b1;
    gap_armed = 1'b0;
    auto_m    = 1'b1;
    wait_sb(120);
    auto_m = 1'b0;
    gap_en = 1'b0;
    tick(20);
    chk("auto_off_sel", int'(sel), m_sel);
    chk("auto_count", n_chg, n_exp);

    // Reset in the middle of HOLD
    expect_step(1);
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (changed) break;
      tick(1);
    end
    chk("pre_rst_changed", int'(changed), 1);
    tick(1);
    btn_up = 1'b0;
    reset_dut();
    tick(20);
    chk("post_rst_sel", int'(sel), 0);
    chk("post_rst_count", n_chg, n_exp);

    // Button held through reset gives no press until re-pressed
    btn_up = 1'b1;
    reset_dut();
    tick(20);
    chk("held_count", n_chg, n_exp);
    btn_up = 1'b0;
    tick(10);
    expect_step(1);
    press_btn(1'b1, 1'b0, 10);
    wait_sb(20);
    tick(6);
    chk("repress_sel", int'(sel), m_sel);

    chk("final_count", n_chg, n_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
